// File: rtl/bsg_cache_sbuf_ctrl.sv
// Two-entry store buffer: in-order enqueue/dequeue with empty pass-through
// and a combinational byte-merge bypass for loads.
//
// state | meaning
// EMPTY | no stored entries; dequeue port mirrors the enqueue inputs
// ONE   | one stored entry at r_head (oldest)
// TWO   | two stored entries; r_head oldest, ~r_head youngest
module bsg_cache_sbuf_ctrl #(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 32,
  localparam int mask_width_p = data_width_p / 8,
  localparam int lg_word_bytes = $clog2(mask_width_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [mask_width_p-1:0] mask_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [addr_width_p-1:0] addr_o,
  output logic [data_width_p-1:0] data_o,
  output logic [mask_width_p-1:0] mask_o,
  input  logic                    yumi_i,
  input  logic [addr_width_p-1:0] bypass_addr_i,
  output logic [data_width_p-1:0] bypass_data_o,
  output logic [mask_width_p-1:0] bypass_mask_o,
  output logic                    empty_o,
  output logic                    full_o
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e                  r_state;
  logic                    r_head;
  logic                    r_empty;
  logic                    r_full;
  logic [addr_width_p-1:0] r_addr [2];
  logic [data_width_p-1:0] r_data [2];
  logic [mask_width_p-1:0] r_mask [2];

  logic w_enq;
  logic w_deq;
  logic w_wr_en;
  logic w_wr_slot;
  logic w_old_hit;
  logic w_yng_hit;

  assign ready_o = ~reset_i & (r_state != TWO);
  assign w_enq   = v_i & ready_o;
  assign v_o     = (r_state != EMPTY) | (v_i & ~reset_i);
  assign w_deq   = yumi_i & v_o;

  // An enqueue that is consumed in the same cycle from EMPTY is never stored.
  assign w_wr_en   = w_enq & ~((r_state == EMPTY) & w_deq);
  assign w_wr_slot = (r_state == EMPTY) ? r_head : ~r_head;

  assign addr_o  = (r_state == EMPTY) ? addr_i : r_addr[r_head];
  assign data_o  = (r_state == EMPTY) ? data_i : r_data[r_head];
  assign mask_o  = (r_state == EMPTY) ? mask_i : r_mask[r_head];
  assign empty_o = r_empty;
  assign full_o  = r_full;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= EMPTY;
      r_head  <= 1'b0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_wr_en) begin
            r_state <= ONE;
            r_empty <= 1'b0;
          end
        end
        ONE: begin
          if (w_deq) r_head <= ~r_head;
          if (w_enq && !w_deq) begin
            r_state <= TWO;
            r_full  <= 1'b1;
          end else if (w_deq && !w_enq) begin
            r_state <= EMPTY;
            r_empty <= 1'b1;
          end
        end
        TWO: begin
          if (w_deq) begin
            r_head  <= ~r_head;
            r_state <= ONE;
            r_full  <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_empty <= 1'b1;
          r_full  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_addr[w_wr_slot] <= addr_i;
      r_data[w_wr_slot] <= data_i;
      r_mask[w_wr_slot] <= mask_i;
    end
  end

  assign w_old_hit = (r_state != EMPTY) &&
    (r_addr[r_head][addr_width_p-1:lg_word_bytes] == bypass_addr_i[addr_width_p-1:lg_word_bytes]);
  assign w_yng_hit = (r_state == TWO) &&
    (r_addr[~r_head][addr_width_p-1:lg_word_bytes] == bypass_addr_i[addr_width_p-1:lg_word_bytes]);

  // Oldest first so the youngest matching byte overwrites it.
  always_comb begin
    bypass_data_o = '0;
    bypass_mask_o = '0;
    for (int j = 0; j < mask_width_p; j++) begin
      if (w_old_hit && r_mask[r_head][j]) begin
        bypass_data_o[8*j+:8] = r_data[r_head][8*j+:8];
        bypass_mask_o[j]      = 1'b1;
      end
      if (w_yng_hit && r_mask[~r_head][j]) begin
        bypass_data_o[8*j+:8] = r_data[~r_head][8*j+:8];
        bypass_mask_o[j]      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
      else $warning("bsg_cache_sbuf_ctrl: yumi_i asserted while v_o is low");
    end
  end

endmodule

// File: tb/tb_bsg_cache_sbuf_ctrl.sv
// Bench for bsg_cache_sbuf_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bsg_cache_sbuf_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [31:0] addr_i;
  logic [63:0] data_i;
  logic [7:0]  mask_i;
  logic        ready_o;
  logic        v_o;
  logic [31:0] addr_o;
  logic [63:0] data_o;
  logic [7:0]  mask_o;
  logic        yumi_i;
  logic [31:0] bypass_addr_i;
  logic [63:0] bypass_data_o;
  logic [7:0]  bypass_mask_o;
  logic        empty_o;
  logic        full_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } ent_t;
  ent_t q[$];

  bsg_cache_sbuf_ctrl #(.data_width_p(64), .addr_width_p(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .addr_i(addr_i),
    .data_i(data_i), .mask_i(mask_i), .ready_o(ready_o), .v_o(v_o),
    .addr_o(addr_o), .data_o(data_o), .mask_o(mask_o), .yumi_i(yumi_i),
    .bypass_addr_i(bypass_addr_i), .bypass_data_o(bypass_data_o),
    .bypass_mask_o(bypass_mask_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of stored entries, updated at each clock edge.
  always @(posedge clk_i) begin
    if (reset_i) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (v_i && !yumi_i) q.push_back('{addr_i, data_i, mask_i});
    end else begin
      logic can_enq;
      can_enq = v_i && (q.size() < 2);
      if (yumi_i) void'(q.pop_front());
      if (can_enq) q.push_back('{addr_i, data_i, mask_i});
    end
  end

  always @(negedge clk_i) begin
    logic        e_v;
    logic [63:0] e_bd;
    logic [7:0]  e_bm;
    e_v = (q.size() > 0) || (v_i && !reset_i);
    chk("ready_o", ready_o, !reset_i && q.size() < 2);
    chk("v_o", v_o, e_v);
    chk("empty_o", empty_o, q.size() == 0);
    chk("full_o", full_o, q.size() == 2);
    if (e_v) begin
      chk("addr_o", addr_o, q.size() > 0 ? q[0].addr : addr_i);
      chk("data_o", data_o, q.size() > 0 ? q[0].data : data_i);
      chk("mask_o", mask_o, q.size() > 0 ? q[0].mask : mask_i);
    end
    e_bd = '0;
    e_bm = '0;
    foreach (q[k]) begin
      if (q[k].addr[31:3] == bypass_addr_i[31:3]) begin
        for (int j = 0; j < 8; j++) begin
          if (q[k].mask[j]) begin
            e_bd[8*j+:8] = q[k].data[8*j+:8];
            e_bm[j] = 1'b1;
          end
        end
      end
    end
    chk("bypass_mask_o", bypass_mask_o, e_bm);
    chk("bypass_data_o", bypass_data_o, e_bd);
  end

  task automatic go(); @(negedge clk_i); endtask
  task automatic nx(); @(posedge clk_i); #1; endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] m, input logic y);
    v_i = v; addr_i = a; data_i = d; mask_i = m; yumi_i = y;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    bypass_addr_i = 32'h0;
    nx(); nx();
    reset_i = 1'b0;

    // pass-through
    drive(1'b1, 32'h100, 64'hAA, 8'hFF, 1'b1);
    go(); chk("pt_v", v_o, 1'b1); chk("pt_data", data_o, 64'hAA);
    nx();
    drive(1'b0, '0, '0, '0, 1'b0);
    go(); chk("pt_empty", empty_o, 1'b1); chk("pt_v_after", v_o, 1'b0);
    nx();

    // fill and drain
    drive(1'b1, 32'h10, 64'hA, 8'hFF, 1'b0); nx();
    drive(1'b1, 32'h20, 64'hB, 8'hFF, 1'b0); nx();
    drive(1'b0, '0, '0, '0, 1'b1);
    go(); chk("fd_full", full_o, 1'b1); chk("fd_ready", ready_o, 1'b0);
    chk("fd_head_a", data_o, 64'hA);
    nx();
    go(); chk("fd_head_b", data_o, 64'hB);
    nx();
    drive(1'b0, '0, '0, '0, 1'b0);
    go(); chk("fd_empty", empty_o, 1'b1);
    nx();

    // streaming in ONE
    drive(1'b1, 32'h30, 64'hA, 8'hFF, 1'b0); nx();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + 32'(i + 1), 64'(11 + i), 8'hFF, 1'b1);
      go(); chk("st_head", data_o, 64'(10 + i));
      chk("st_one", {full_o, empty_o}, 2'b00);
      nx();
    end
    drive(1'b0, '0, '0, '0, 1'b1);
    go(); chk("st_head_d", data_o, 64'hD);
    nx();
    drive(1'b0, '0, '0, '0, 1'b0);

    // bypass merge
    drive(1'b1, 32'h40, 64'h11111111_11111111, 8'h0F, 1'b0); nx();
    drive(1'b1, 32'h44, 64'h22222222_22222222, 8'h03, 1'b0); nx();
    drive(1'b0, '0, '0, '0, 1'b0);
    bypass_addr_i = 32'h40;
    go(); chk("bp_mask", bypass_mask_o, 8'h0F);
    chk("bp_data", bypass_data_o, 64'h00000000_11112222);
    bypass_addr_i = 32'h80;
    go(); chk("bp_miss", bypass_mask_o, 8'h00);
    nx();
    bypass_addr_i = 32'h40;

    // reset mid-operation with a full buffer
    reset_i = 1'b1; yumi_i = 1'b1; nx();
    reset_i = 1'b0; yumi_i = 1'b0;
    go(); chk("rm_empty", empty_o, 1'b1); chk("rm_v", v_o, 1'b0);
    chk("rm_bp", bypass_mask_o, 8'h00);
    nx();

    // illegal yumi while empty must not change state
    drive(1'b0, '0, '0, '0, 1'b1); nx();
    drive(1'b0, '0, '0, '0, 1'b0);
    go(); chk("il_empty", empty_o, 1'b1); chk("il_v", v_o, 1'b0);
    nx();

    // mixed traffic over a few words, yumi only when legal
    for (int i = 0; i < 300; i++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      drive(v, 32'h200 + 32'($urandom_range(0, 2) * 8) + 32'($urandom_range(0, 7)),
            {$urandom, $urandom}, 8'($urandom), 1'b0);
      yumi_i = ((q.size() > 0) || v) && ($urandom_range(0, 2) != 0);
      bypass_addr_i = 32'h200 + 32'($urandom_range(0, 3) * 8);
      nx();
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    go();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_cache_sbuf_ctrl.md
# bsg_cache_sbuf_ctrl

Two-entry store buffer for the cache data path. Stores enter on a valid/ready port, are held in arrival order, and drain oldest-first to data-memory write logic over a valid/yumi port. An empty buffer passes a store straight through in the same cycle. A combinational bypass port merges buffered bytes into load data so loads see stores that have not yet drained. The block owns its own two-entry storage, holds the control state machine, and produces the per-entry enables and muxing internally.

## Interface
- data_width_p, 64, store data width in bits; must be a multiple of 8.
- addr_width_p, 32, byte address width.
- mask_width_p, data_width_p/8, byte-enable width; derived, not overridden.
- lg_word_bytes, log2(mask_width_p), number of word-offset address bits; derived.
- clk_i  input  1  clock; all state changes on posedge.
- reset_i  input  1  synchronous, active-high reset.
- v_i  input  1  enqueue valid.
- addr_i  input  addr_width_p  store byte address.
- data_i  input  data_width_p  store data.
- mask_i  input  mask_width_p  store byte mask.
- ready_o  output  1  enqueue ready; a transfer occurs when v_i & ready_o.
- v_o  output  1  dequeue valid.
- addr_o  output  addr_width_p  head store address.
- data_o  output  data_width_p  head store data.
- mask_o  output  mask_width_p  head store mask.
- yumi_i  input  1  dequeue accept; legal only when v_o=1.
- bypass_addr_i  input  addr_width_p  load address to compare against buffered stores.
- bypass_data_o  output  data_width_p  merged buffered bytes; bytes with no hit are 0.
- bypass_mask_o  output  mask_width_p  bytes supplied by the buffer.
- empty_o  output  1  count==0.
- full_o  output  1  count==2.

## Operation
- State is count in {EMPTY=0, ONE=1, TWO=2}, plus two entry registers. Each entry holds addr, data and mask, tagged oldest and youngest.
- ready_o = ~reset_i & (count != 2). ready_o does not depend on yumi_i, so no combinational path exists from yumi_i to ready_o.
- Dequeue port in EMPTY: v_o = v_i & ~reset_i, and addr_o, data_o and mask_o are driven from the inputs (pass-through).
- Dequeue port in ONE or TWO: v_o = 1 and the outputs come from the oldest entry.
- Transitions, with enq = v_i & ready_o and deq = yumi_i:
  - EMPTY: enq & deq keeps EMPTY and nothing is stored. enq only writes the input to an entry and moves to ONE.
  - ONE: enq only writes the input as youngest and moves to TWO. deq only moves to EMPTY. enq & deq stays in ONE, and the input becomes the sole (oldest) entry.
  - TWO: deq moves to ONE, and the youngest entry becomes oldest. enq cannot occur because ready_o=0.
- Bypass compares bypass_addr_i[addr_width_p-1:lg_word_bytes] with each valid stored entry's address in the same bit range.
  - For each byte j, the youngest matching entry with mask[j]=1 supplies the byte and sets bypass_mask_o[j]=1.
  - Only registered entries participate. The current-cycle input and a pass-through store are not bypassed.
  - Bypass is purely combinational from the current state.
- yumi_i while v_o=0 is illegal and is flagged by a simulation assertion. The state must not change in that case.
- Entry registers are written only on enq. Entry contents are not cleared on dequeue or reset, and stale contents are never observable because validity is derived from count.

## Timing
- Reset: count=0. During reset and on the first cycle after it: ready_o=0 during reset, v_o=0, empty_o=1, full_o=0, bypass_mask_o=0, bypass_data_o=0.
- Reset asserted mid-operation discards all entries at the next edge, whatever v_i or yumi_i are doing in that cycle.
- Pass-through latency is 0 cycles in EMPTY.
- A stored entry is visible on the dequeue port and the bypass port in the cycle after the enqueue edge.
- Throughput is one enqueue and one dequeue per cycle in ONE; FIFO order is always preserved.
- empty_o and full_o are decoded from registered count only.

## Test plan
- Reset then pass-through: reset_i=1 for 2 cycles; then v_i=1, addr_i=0x100, data_i=0xAA, mask_i=0xFF, yumi_i=1 -> v_o=1 and data_o=0xAA in the same cycle; the next cycle has empty_o=1 and v_o=0.
- Fill and drain: enqueue A (0x10), then B (0x20) with yumi_i=0 -> full_o=1, ready_o=0. Then yumi_i=1 for 2 cycles -> data_o is A, then B; the buffer ends with empty_o=1.
- Streaming in ONE: preload A, then enqueue B, C and D each with yumi_i=1 -> the dequeue sequence is A, B, C, D with count staying at 1 throughout.
- Bypass merge: store X at addr 0x40 with mask 0x0F and data 0x11111111_11111111, then Y at 0x44 (same word) with mask 0x03 and data 0x22222222_22222222. bypass_addr_i=0x40 -> bypass_mask_o=0x0F and bypass_data_o=0x00000000_11112222. bypass_addr_i=0x80 -> mask 0x00.
- Reset mid-operation: full buffer, then reset_i=1 together with yumi_i=1 -> the next cycle has count=0, v_o=0 and bypass_mask_o=0.
- Illegal yumi: yumi_i=1 while EMPTY with v_i=0 -> assertion fires and count remains 0.
